bu_s0_modred: RTL and testbench

//  Downstream stage of the stage-0 butterfly (BU_S0) in the radix-16 16384-point NTT pipeline.
//  - Consumes BU_S0's raw outputs:
//    - the 192-bit zero-extended sum word;
//    - the 192-bit packed operand word {32'd0,b,32'd0,a}.
//  - Produces canonical residues mod P: (a+b) mod P and (a-b) mod P.
//  - Two-stage valid/ready pipeline with backpressure, plus input-legality checking.

---
 rtl/bffp_pkg.sv | 16 +
 rtl/mod_corr.sv | 19 +
 rtl/bu_s0_modred.sv | 104 ++++++++++
 tb/tb_bu_s0_modred.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bffp_pkg.sv
// Shared widths, modulus and BU_S0 pack/unpack field offsets for the stage-0 butterfly path.
package bffp_pkg;

  localparam int P_WIDTH = 64;
  localparam int D_WIDTH = 192;
  localparam int SUM_W   = P_WIDTH + 1;
  localparam logic [P_WIDTH-1:0] MODULUS = 64'hFFFF_FFFF_0000_0001;

  // Packed operand word layout: {pad1, b, pad0, a}
  localparam int A_LSB    = 0;
  localparam int PAD0_LSB = 64;
  localparam int B_LSB    = 96;
  localparam int PAD1_LSB = 160;
  localparam int PAD_W    = 32;

endpackage

// File: rtl/mod_corr.sv
// Single conditional correction that maps a 65-bit sum or borrow-tagged difference into [0, P).
module mod_corr
  import bffp_pkg::*;
(
  input  logic [SUM_W-1:0]   sum,
  input  logic [SUM_W-1:0]   dif,
  output logic [P_WIDTH-1:0] r0,
  output logic [P_WIDTH-1:0] r1
);

  localparam logic [SUM_W-1:0] P_EXT = {1'b0, MODULUS};

  // Only the low 64 bits survive, so the subtraction can be done at residue width.
  always_comb begin
    r0 = (sum >= P_EXT) ? (sum[P_WIDTH-1:0] - MODULUS) : sum[P_WIDTH-1:0];
    r1 = dif[P_WIDTH] ? (dif[P_WIDTH-1:0] + MODULUS) : dif[P_WIDTH-1:0];
  end

endmodule

// File: rtl/bu_s0_modred.sv
// Two-stage valid/ready modular reduction of BU_S0 outputs into canonical (a+b) mod P and (a-b) mod P.
module bu_s0_modred
  import bffp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] R0_in,
  input  logic [D_WIDTH-1:0] R1_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] R0_out,
  output logic [P_WIDTH-1:0] R1_out,
  output logic               out_err,
  output logic               err_sticky,
  input  logic               err_clr
);

  logic [P_WIDTH-1:0] a;
  logic [P_WIDTH-1:0] b;
  logic [SUM_W-1:0]   sum_ref;
  logic [SUM_W-1:0]   in_dif;
  logic               pad_bad;
  logic               in_err;

  logic               s1_valid;
  logic [SUM_W-1:0]   s1_sum;
  logic [SUM_W-1:0]   s1_dif;
  logic               s1_err;

  logic               en1;
  logic               en2;
  logic [P_WIDTH-1:0] corr_r0;
  logic [P_WIDTH-1:0] corr_r1;

  assign a = R1_in[A_LSB +: P_WIDTH];
  assign b = R1_in[B_LSB +: P_WIDTH];

  assign sum_ref = {1'b0, a} + {1'b0, b};
  assign in_dif  = {1'b0, a} - {1'b0, b};

  assign pad_bad = (|R1_in[PAD0_LSB +: PAD_W]) | (|R1_in[PAD1_LSB +: PAD_W]) |
                   (|R0_in[D_WIDTH-1:SUM_W]);

  assign in_err = (a >= MODULUS) | (b >= MODULUS) | pad_bad |
                  (R0_in[SUM_W-1:0] != sum_ref);

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  // Data only loads with a valid sample so bubbles leave the previous values in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_dif   <= '0;
      s1_err   <= 1'b0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= R0_in[SUM_W-1:0];
        s1_dif <= in_dif;
        s1_err <= in_err;
      end
    end
  end

  mod_corr u_mod_corr (
    .sum (s1_sum),
    .dif (s1_dif),
    .r0  (corr_r0),
    .r1  (corr_r1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      R0_out    <= '0;
      R1_out    <= '0;
      out_err   <= 1'b0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        R0_out  <= corr_r0;
        R1_out  <= corr_r1;
        out_err <= s1_err;
      end
    end
  end

  // Clear has priority over an error delivered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_err) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bu_s0_modred.sv
// Directed and randomized checks of bu_s0_modred against an independent (a+b)/(a-b) mod P model.
module tb_bu_s0_modred;

  localparam logic [63:0] MOD = 64'hFFFF_FFFF_0000_0001;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] R0_in;
  logic [191:0] R1_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  R0_out;
  logic [63:0]  R1_out;
  logic         out_err;
  logic         err_sticky;
  logic         err_clr;

  int tests_run;
  int tests_failed;

  bu_s0_modred dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .R0_in      (R0_in),
    .R1_in      (R1_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .R0_out     (R0_out),
    .R1_out     (R1_out),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [191:0] pack_r1(input logic [63:0] a, input logic [63:0] b);
    return {32'd0, b, 32'd0, a};
  endfunction

  function automatic logic [191:0] pack_r0(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {127'd0, s};
  endfunction

  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MOD}) s = s - {1'b0, MOD};
    return s[63:0];
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
    if (a >= b) return a - b;
    return MOD - (b - a);
  endfunction

  task automatic drive_sample(input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    R0_in    = pack_r0(a, b);
    R1_in    = pack_r1(a, b);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    R0_in = '0; R1_in = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || err_sticky !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got valid=%b err=%b sticky=%b expected 0 0 0", out_valid, out_err, err_sticky);
    end
    tests_run++;
    if (R0_out !== 64'd0 || R1_out !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h %h expected 0 0", R0_out, R1_out);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    @(negedge clk);
    out_ready = 1'b1;
    drive_sample(64'd5, 64'd3);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency1: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_valid: got valid=%b err=%b expected 1 0", out_valid, out_err);
    end
    tests_run++;
    if (R0_out !== 64'd8 || R1_out !== 64'd2) begin
      tests_failed++;
      $display("[TB] FAIL basic_data: got %h %h expected 8 2", R0_out, R1_out);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_boundary;
    logic [63:0] ta[5];
    logic [63:0] tb[5];
    logic [63:0] e0[5];
    logic [63:0] e1[5];
    ta[0] = MOD - 64'd1;        tb[0] = 64'd1;
    e0[0] = 64'd0;              e1[0] = 64'hFFFF_FFFE_FFFF_FFFF;
    ta[1] = 64'd1;              tb[1] = 64'd2;
    e0[1] = 64'd3;              e1[1] = 64'hFFFF_FFFF_0000_0000;
    ta[2] = 64'd0;              tb[2] = 64'd0;
    e0[2] = 64'd0;              e1[2] = 64'd0;
    ta[3] = MOD - 64'd1;        tb[3] = MOD - 64'd1;
    e0[3] = 64'hFFFF_FFFE_FFFF_FFFF; e1[3] = 64'd0;
    ta[4] = 64'd0;              tb[4] = MOD - 64'd1;
    e0[4] = 64'hFFFF_FFFF_0000_0000; e1[4] = 64'd1;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) drive_sample(ta[k], tb[k]);
      else in_valid = 1'b0;
      #1;
      if (k >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || R0_out !== e0[k-2] || R1_out !== e1[k-2] || out_err !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL boundary_%0d: got v=%b %h %h err=%b expected v=1 %h %h err=0",
                   k-2, out_valid, R0_out, R1_out, out_err, e0[k-2], e1[k-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 1'b0;
    drive_sample(64'd10, 64'd20);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_accept0: got in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    drive_sample(64'd100, 64'd1);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_accept1: got in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    drive_sample(64'd7, 64'd7);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_full: got in_ready=%b expected 0", in_ready);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || R0_out !== 64'd30 || R1_out !== 64'hFFFF_FFFE_FFFF_FFF7 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_stall_hold: got v=%b %h %h rdy=%b expected v=1 1e fffffffefffffff7 rdy=0",
               out_valid, R0_out, R1_out, in_ready);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release_ready: got in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || R0_out !== 64'd101 || R1_out !== 64'd99) begin
      tests_failed++;
      $display("[TB] FAIL bp_out1: got v=%b %h %h expected v=1 65 63", out_valid, R0_out, R1_out);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || R0_out !== 64'd14 || R1_out !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL bp_out2: got v=%b %h %h expected v=1 e 0", out_valid, R0_out, R1_out);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_errors;
    logic [191:0] w0[7];
    logic [191:0] w1[7];
    logic         ee[7];
    w0[0] = pack_r0(MOD, 64'd0);   w1[0] = pack_r1(MOD, 64'd0);   ee[0] = 1'b1;
    w0[1] = pack_r0(64'd5, 64'd3); w1[1] = pack_r1(64'd5, 64'd3) | (192'd1 << 64);  ee[1] = 1'b1;
    w0[2] = pack_r0(64'd5, 64'd3); w1[2] = pack_r1(64'd5, 64'd3) | (192'd1 << 191); ee[2] = 1'b1;
    w0[3] = pack_r0(64'd5, 64'd3) | (192'd1 << 100); w1[3] = pack_r1(64'd5, 64'd3); ee[3] = 1'b1;
    w0[4] = 192'd9;                w1[4] = pack_r1(64'd5, 64'd3); ee[4] = 1'b1;
    w0[5] = pack_r0(64'd0, MOD);   w1[5] = pack_r1(64'd0, MOD);   ee[5] = 1'b1;
    w0[6] = pack_r0(64'd5, 64'd3); w1[6] = pack_r1(64'd5, 64'd3); ee[6] = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 7) begin
        in_valid = 1'b1; R0_in = w0[k]; R1_in = w1[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 2) begin
        tests_run++;
        if (err_sticky !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL err_sticky_before: got %b expected 0", err_sticky);
        end
      end
      if (k >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_err !== ee[k-2]) begin
          tests_failed++;
          $display("[TB] FAIL err_case_%0d: got v=%b err=%b expected v=1 err=%b", k-2, out_valid, out_err, ee[k-2]);
        end
      end
    end
    tests_run++;
    if (err_sticky !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky_set: got %b expected 1", err_sticky);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    tests_run++;
    if (err_sticky !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_clr: got %b expected 0", err_sticky);
    end
    @(negedge clk);
    in_valid = 1'b1; R0_in = pack_r0(MOD, 64'd0); R1_in = pack_r1(MOD, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_clr_race_setup: got v=%b err=%b expected 1 1", out_valid, out_err);
    end
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    tests_run++;
    if (err_sticky !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_clr_priority: got %b expected 0", err_sticky);
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    out_ready = 1'b0;
    drive_sample(64'd1, 64'd1);
    @(negedge clk);
    drive_sample(64'd2, 64'd2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_full: got v=%b rdy=%b expected 1 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive_sample(64'd3, 64'd3);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || R0_out !== 64'd0 || R1_out !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_clear: got v=%b %h %h expected 0 0 0", out_valid, R0_out, R1_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rst_mid_stale_%0d: got out_valid=%b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_random;
    localparam int N = 10000;
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q0;
    logic [63:0] q1;
    int sent;
    int recv;
    int cyc;
    logic acc;
    sent = 0; recv = 0; cyc = 0; acc = 1'b0;
    in_valid = 1'b0;
    while (recv < N && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) a = MOD - 64'd1 - {56'd0, 8'($urandom)};
        if ($urandom_range(0, 15) == 0) b = MOD - 64'd1 - {56'd0, 8'($urandom)};
        if (a >= MOD) a = a - MOD;
        if (b >= MOD) b = b - MOD;
        drive_sample(a, b);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp0.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL rand_unexpected: got output %h %h expected none", R0_out, R1_out);
        end else begin
          q0 = exp0.pop_front();
          q1 = exp1.pop_front();
          if (R0_out !== q0 || R1_out !== q1 || out_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_%0d: got %h %h err=%b expected %h %h err=0", recv, R0_out, R1_out, out_err, q0, q1);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp0.push_back(ref_add(R1_in[63:0], R1_in[159:96]));
        exp1.push_back(ref_sub(R1_in[63:0], R1_in[159:96]));
        sent++;
        acc = 1'b1;
      end
    end
    tests_run++;
    if (recv != N || exp0.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_count: got %0d outputs (%0d pending) expected %0d", recv, exp0.size(), N);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset;
    test_basic;
    test_boundary;
    test_backpressure;
    test_errors;
    test_reset_midstream;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
